// File: rtl/clause_len_scan.sv
// Clause-length scan sequencer: streams a clause bin from RAM, writes per-clause literal counts, summarizes the bin.
// Optional CLEN_EARLY_ABORT_EN: stop the scan once an empty clause has been written.
module clause_len_scan #(
  parameter int NUM     = 8,
  parameter int LEN_W   = 4,
  parameter int CADDR_W = 6,
  parameter int CNT_W   = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [CADDR_W:0]   num_clauses_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               rd_en_o,
  output logic [CADDR_W-1:0] rd_addr_o,
  input  logic [NUM*2-1:0]   rd_data_i,
  output logic               len_wr_en_o,
  output logic [CADDR_W-1:0] len_wr_addr_o,
  output logic [LEN_W-1:0]   len_wr_data_o,
  output logic [CNT_W-1:0]   unit_cnt_o,
  output logic               empty_found_o,
  output logic [CADDR_W-1:0] first_empty_addr_o,
  output logic [LEN_W-1:0]   max_len_o
);

  // state | meaning
  // IDLE  | waiting for start_i
  // SCAN  | issuing one clause read per cycle
  // DRAIN | last read issued, waiting for the last length write
  // DONE  | one-cycle done pulse, summary valid
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;

  logic [CADDR_W-1:0] rd_addr_q;
  logic [CADDR_W:0]   rem_q;
  logic               p1_valid_q;
  logic               p1_last_q;
  logic [CADDR_W-1:0] p1_addr_q;
  logic               wr_last_q;
  logic [LEN_W-1:0]   row_len;
  logic               start_acc;
  logic               rd_last;
  logic               abort;

  assign start_acc = (state_q == S_IDLE) && start_i;
  assign rd_last   = (rem_q == '0);

`ifdef CLEN_EARLY_ABORT_EN
  // The write of an empty clause kills everything behind it in the pipe.
  assign abort = len_wr_en_o && (len_wr_data_o == '0);
`else
  assign abort = 1'b0;
`endif

  assign rd_en_o   = (state_q == S_SCAN) && !abort;
  assign rd_addr_o = rd_addr_q;
  assign busy_o    = (state_q == S_SCAN) || (state_q == S_DRAIN);
  assign done_o    = (state_q == S_DONE);

  always_comb begin
    row_len = '0;
    for (int i = 0; i < NUM; i++) begin
      row_len = row_len + LEN_W'(|rd_data_i[2*i +: 2]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = (num_clauses_i == '0) ? S_DONE : S_SCAN;
      end
      S_SCAN: begin
        if (abort)        state_d = S_DONE;
        else if (rd_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort || (len_wr_en_o && wr_last_q)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read address up-counter plus remaining-reads down-counter; terminal count ends SCAN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr_q <= '0;
      rem_q     <= '0;
    end else if (start_acc) begin
      rd_addr_q <= '0;
      rem_q     <= num_clauses_i - (CADDR_W+1)'(1);
    end else if (rd_en_o) begin
      rd_addr_q <= rd_addr_q + CADDR_W'(1);
      rem_q     <= rem_q - (CADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_valid_q    <= 1'b0;
      p1_last_q     <= 1'b0;
      p1_addr_q     <= '0;
      len_wr_en_o   <= 1'b0;
      len_wr_addr_o <= '0;
      len_wr_data_o <= '0;
      wr_last_q     <= 1'b0;
    end else begin
      p1_valid_q  <= rd_en_o;
      p1_last_q   <= rd_en_o && rd_last;
      p1_addr_q   <= rd_addr_q;
      len_wr_en_o <= p1_valid_q && !abort;
      wr_last_q   <= p1_valid_q && p1_last_q && !abort;
      if (p1_valid_q) begin
        len_wr_addr_o <= p1_addr_q;
        len_wr_data_o <= row_len;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      unit_cnt_o         <= '0;
      empty_found_o      <= 1'b0;
      first_empty_addr_o <= '0;
      max_len_o          <= '0;
    end else if (start_acc) begin
      unit_cnt_o         <= '0;
      empty_found_o      <= 1'b0;
      first_empty_addr_o <= '0;
      max_len_o          <= '0;
    end else if (len_wr_en_o) begin
      if ((len_wr_data_o == LEN_W'(1)) && (unit_cnt_o != '1))
        unit_cnt_o <= unit_cnt_o + CNT_W'(1);
      if (len_wr_data_o == '0) begin
        empty_found_o <= 1'b1;
        if (!empty_found_o) first_empty_addr_o <= len_wr_addr_o;
      end
      if (len_wr_data_o > max_len_o) max_len_o <= len_wr_data_o;
    end
  end

endmodule
